firebird7_in_gate1_tessent_data_capture_tdr_w19: RTL and testbench

FIREBIRD7_IN_GATE1_TESSENT_DATA_CAPTURE_TDR_W19 -- requirements
Module: firebird7_in_gate1_tessent_data_capture_tdr_w19

---
 rtl/firebird7_in_gate1_tessent_tdr_pkg.sv | 23 ++
 rtl/firebird7_in_gate1_tessent_tdr_update_reg.sv | 25 ++
 rtl/firebird7_in_gate1_tessent_data_capture_tdr_w19.sv | 78 +++++++
 tb/tb_firebird7_in_gate1_tessent_data_capture_tdr_w19.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared definitions for the firebird7 gate1 data-capture TDR.
//   TDR_WIDTH    : default functional data width
//   chain_len()  : scan chain length for a given data width (data + select + mismatch)
//   SELECT_BIT   : chain index of the select bit at the default width
//   MISMATCH_BIT : chain index of the mismatch flag at the default width
//   tdr_update_t : {select, data} view of the update register at the default width
package firebird7_in_gate1_tessent_tdr_pkg;

  localparam int unsigned TDR_WIDTH = 19;

  function automatic int unsigned chain_len(input int unsigned w);
    return w + 2;
  endfunction

  localparam int unsigned SELECT_BIT   = TDR_WIDTH;
  localparam int unsigned MISMATCH_BIT = TDR_WIDTH + 1;

  typedef struct packed {
    logic                 select;
    logic [TDR_WIDTH-1:0] data;
  } tdr_update_t;

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_update_reg.sv
// Update register of the data-capture TDR.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears q
//   load : loads d into q on the next edge
//   d    : value to load
//   q    : registered contents
module firebird7_in_gate1_tessent_tdr_update_reg #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_capture_tdr_w19.sv
// IJTAG data-capture TDR: captures the functional value seen at the data-mux
// output together with the current select bit and a mismatch flag (functional
// value differs from the last programmed value), shifts it out LSB-first,
// and updates {select, data} that drive the downstream data mux.
//   ijtag_tck          : clock, rising edge
//   ijtag_reset        : synchronous active-high reset
//   ijtag_sel          : TDR selected in the active scan path
//   ijtag_ce/se/ue     : capture / shift / update enables (ce wins over se)
//   ijtag_si, ijtag_so : scan in, scan out (so = shift[0], combinational)
//   functional_data_in : value observed at the data-mux output
//   ijtag_data_out     : registered update data to the mux
//   ijtag_select       : registered update select bit to the mux
module firebird7_in_gate1_tessent_data_capture_tdr_w19
  import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
  parameter int unsigned WIDTH = TDR_WIDTH
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] functional_data_in,
  output logic [WIDTH-1:0] ijtag_data_out,
  output logic             ijtag_select
);

  localparam int unsigned CHAIN_LEN = chain_len(WIDTH);
  // Chain indices follow WIDTH when it differs from the package default.
  localparam int unsigned SEL_IDX   = SELECT_BIT - TDR_WIDTH + WIDTH;
  localparam int unsigned MIS_IDX   = MISMATCH_BIT - TDR_WIDTH + WIDTH;

  logic [CHAIN_LEN-1:0] shift_q;
  logic [WIDTH:0]       upd_q;
  logic                 mismatch;
  logic                 upd_load;

  // Compared against the update register even while select is 0, so the flag
  // always tells whether the mux output equals the last programmed value.
  assign mismatch = (functional_data_in != upd_q[WIDTH-1:0]);

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      shift_q <= '0;
    end else if (ijtag_sel && ijtag_ce) begin
      shift_q <= {mismatch, upd_q[WIDTH], functional_data_in};
    end else if (ijtag_sel && ijtag_se) begin
      shift_q <= {ijtag_si, shift_q[CHAIN_LEN-1:1]};
    end
  end

  // Update samples shift_q as it stands before this edge, so ue alongside
  // ce or se takes the pre-capture / pre-shift contents. Mismatch bit is
  // never transferred.
  assign upd_load = ijtag_sel && ijtag_ue;

  firebird7_in_gate1_tessent_tdr_update_reg #(
    .W(WIDTH + 1)
  ) u_update_reg (
    .clk  (ijtag_tck),
    .rst  (ijtag_reset),
    .load (upd_load),
    .d    (shift_q[SEL_IDX:0]),
    .q    (upd_q)
  );

  assign ijtag_so       = shift_q[0];
  assign ijtag_data_out = upd_q[WIDTH-1:0];
  assign ijtag_select   = upd_q[WIDTH];

  // MIS_IDX is the top of the chain; kept as a named index for readability.
  logic unused_idx;
  assign unused_idx = shift_q[MIS_IDX];

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_capture_tdr_w19.sv
module tb_firebird7_in_gate1_tessent_data_capture_tdr_w19;
  import firebird7_in_gate1_tessent_tdr_pkg::*;

  logic        tck;
  logic        rst;
  logic        sel, ce, se, ue, si;
  logic        so;
  logic [18:0] fdi;
  logic [18:0] data_out;
  logic        select;

  int checks;
  int failures;

  firebird7_in_gate1_tessent_data_capture_tdr_w19 #(
    .WIDTH(19)
  ) dut (
    .ijtag_tck          (tck),
    .ijtag_reset        (rst),
    .ijtag_sel          (sel),
    .ijtag_ce           (ce),
    .ijtag_se           (se),
    .ijtag_ue           (ue),
    .ijtag_si           (si),
    .ijtag_so           (so),
    .functional_data_in (fdi),
    .ijtag_data_out     (data_out),
    .ijtag_select       (select)
  );

  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  typedef struct {
    logic        psel;
    logic [18:0] pdata;
    logic [18:0] fdi;
    logic [20:0] exp_word;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic idle();
    sel = 1'b1; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic shift_in(input logic [20:0] v);
    se = 1'b1;
    for (int i = 0; i < 21; i++) begin
      si = v[i];
      tick();
    end
    se = 1'b0;
    si = 1'b0;
  endtask

  task automatic program_upd(input logic s, input logic [18:0] d);
    shift_in({1'b0, s, d});
    ue = 1'b1;
    tick();
    ue = 1'b0;
  endtask

  task automatic capture(input logic [18:0] v);
    fdi = v;
    ce = 1'b1;
    tick();
    ce = 1'b0;
  endtask

  task automatic unload(output logic [20:0] w);
    se = 1'b1;
    si = 1'b0;
    for (int i = 0; i < 21; i++) begin
      w[i] = so;
      tick();
    end
    se = 1'b0;
  endtask

  // Reference model: chain contents and update register as plain words.
  logic [20:0] m_shift;
  logic [19:0] m_upd;

  task automatic model_step(input logic r, input logic s_, input logic c_,
                            input logic e_, input logic u_, input logic i_,
                            input logic [18:0] f_);
    logic [20:0] pre;
    pre = m_shift;
    if (r) begin
      m_shift = '0;
      m_upd   = '0;
    end else if (s_) begin
      if (c_)
        m_shift = {21'((f_ != m_upd[18:0]) ? 1 : 0) << 20} | (21'(m_upd[19]) << 19) | 21'(f_);
      else if (e_)
        m_shift = (m_shift >> 1) | (21'(i_) << 20);
      if (u_)
        m_upd = pre[19:0];
    end
  endtask

  logic [20:0]  word;
  tdr_update_t  exp_upd;
  logic [18:0]  hold_data;
  logic         hold_sel;
  logic         hold_so;

  initial begin
    checks   = 0;
    failures = 0;
    fdi      = '0;
    idle();

    vecs[0] = '{psel: 1'b0, pdata: 19'h00000, fdi: 19'h2AAAA, exp_word: 21'h12AAAA};
    vecs[1] = '{psel: 1'b1, pdata: 19'h15555, fdi: 19'h15555, exp_word: 21'h095555};
    vecs[2] = '{psel: 1'b1, pdata: 19'h7FFFF, fdi: 19'h7FFFF, exp_word: 21'h0FFFFF};
    vecs[3] = '{psel: 1'b0, pdata: 19'h12345, fdi: 19'h12346, exp_word: 21'h112346};
    vecs[4] = '{psel: 1'b1, pdata: 19'h00000, fdi: 19'h00000, exp_word: 21'h080000};

    // Reset state
    do_reset();
    chk("reset_so", 32'(so), 0);
    chk("reset_select", 32'(select), 0);
    chk("reset_data", 32'(data_out), 0);

    // Program / capture / unload vectors
    for (int v = 0; v < 5; v++) begin
      do_reset();
      program_upd(vecs[v].psel, vecs[v].pdata);
      exp_upd.select = vecs[v].psel;
      exp_upd.data   = vecs[v].pdata;
      chk("prog_select", 32'(select), 32'(exp_upd.select));
      chk("prog_data", 32'(data_out), 32'(exp_upd.data));
      capture(vecs[v].fdi);
      chk("cap_so", 32'(so), 32'(vecs[v].fdi[0]));
      unload(word);
      chk("unload_word", 32'(word), 32'(vecs[v].exp_word));
    end

    // ce and se together: capture wins, no shift
    do_reset();
    fdi = 19'h7FFFF;
    ce = 1'b1; se = 1'b1; si = 1'b0;
    tick();
    ce = 1'b0; se = 1'b0;
    chk("ce_se_so", 32'(so), 1);
    unload(word);
    chk("ce_se_word", 32'(word), 32'h17FFFF);

    // Reset in the middle of a shift
    do_reset();
    program_upd(1'b1, 19'h15555);
    se = 1'b1; si = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    ue = 1'b1; ce = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; ue = 1'b0; ce = 1'b0; se = 1'b0; si = 1'b0;
    chk("midrst_so", 32'(so), 0);
    chk("midrst_select", 32'(select), 0);
    chk("midrst_data", 32'(data_out), 0);
    ue = 1'b1;
    tick();
    ue = 1'b0;
    chk("midrst_ue_select", 32'(select), 0);
    chk("midrst_ue_data", 32'(data_out), 0);
    unload(word);
    chk("midrst_word", 32'(word), 0);

    // Deselected: everything holds for 30 cycles
    do_reset();
    program_upd(1'b1, 19'h0F0F0);
    shift_in(21'h1A5A5A);
    hold_data = data_out;
    hold_sel  = select;
    hold_so   = so;
    sel = 1'b0; si = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ce = 1'($urandom_range(0, 1));
      se = 1'($urandom_range(0, 1));
      ue = 1'($urandom_range(0, 1));
      fdi = 19'($urandom);
      tick();
      if (data_out !== hold_data || select !== hold_sel || so !== hold_so)
        chk("desel_hold", {data_out, select, so}, {hold_data, hold_sel, hold_so});
    end
    chk("desel_data", 32'(data_out), 32'h0F0F0);
    chk("desel_select", 32'(select), 1);
    idle();
    unload(word);
    chk("desel_word", 32'(word), 32'h1A5A5A);

    // ue on the 21st shift takes the pre-edge chain contents
    do_reset();
    se = 1'b1; si = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    ue = 1'b1;
    tick();
    ue = 1'b0; se = 1'b0; si = 1'b0;
    chk("ue_last_select", 32'(select), 1);
    chk("ue_last_data", 32'(data_out), 32'h7FFFE);

    // Randomized run against the reference model
    do_reset();
    m_shift = '0;
    m_upd   = '0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      sel = ($urandom_range(0, 7) != 0);
      ce  = ($urandom_range(0, 5) == 0);
      se  = ($urandom_range(0, 3) != 0);
      ue  = ($urandom_range(0, 7) == 0);
      si  = 1'($urandom_range(0, 1));
      fdi = ($urandom_range(0, 3) == 0) ? m_upd[18:0] : 19'($urandom);
      model_step(rst, sel, ce, se, ue, si, fdi);
      tick();
      chk("rand_so", 32'(so), 32'(m_shift[0]));
      chk("rand_select", 32'(select), 32'(m_upd[19]));
      chk("rand_data", 32'(data_out), 32'(m_upd[18:0]));
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
